// File: rtl/div_pkg.sv
// Shared encodings and constants for the execute-stage divide sequencer.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } div_state_e;

  localparam logic        OP_QUO       = 1'b0;
  localparam logic        OP_REM       = 1'b1;
  localparam logic [15:0] DBZ_QUOTIENT = 16'hFFFF;

  localparam int DEF_TIMEOUT_CYCLES = 32;

endpackage

// File: rtl/div_issue_ctrl.sv
// Sequences one divide at a time: accept, start pulse, wait for done (or timeout), respond; normal op rsp_valid at accept+22, divide-by-zero at accept+1.
// Requests are accepted only in IDLE; the response is held stable until rsp_ready, and no request is taken on the handshake cycle.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_dividend,
  input  logic [15:0]      req_divisor,
  input  logic             req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             div_start,
  output logic [15:0]      div_dividend,
  output logic [15:0]      div_divisor,
  input  logic [15:0]      div_quotient,
  input  logic [15:0]      div_remainder,
  input  logic             div_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             rsp_dbz,
  output logic             busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  div_state_e       state_q,     state_d;
  logic             div_start_q, div_start_d;
  logic [15:0]      dividend_q,  dividend_d;
  logic [15:0]      divisor_q,   divisor_d;
  logic             op_q,        op_d;
  logic [TAG_W-1:0] tag_q,       tag_d;
  logic [15:0]      rsp_data_q,  rsp_data_d;
  logic             rsp_err_q,   rsp_err_d;
  logic             rsp_dbz_q,   rsp_dbz_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  always_comb begin
    state_d     = state_q;
    div_start_d = 1'b0;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    op_d        = op_q;
    tag_d       = tag_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_dbz_d   = rsp_dbz_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          dividend_d = req_dividend;
          divisor_d  = req_divisor;
          op_d       = req_op;
          tag_d      = req_tag;
          rsp_err_d  = 1'b0;
          if (req_divisor == 16'd0) begin
            // Divider never sees a zero divisor; the result is synthesised here.
            state_d    = ST_RESP;
            rsp_dbz_d  = 1'b1;
            rsp_data_d = (req_op == OP_REM) ? req_dividend : DBZ_QUOTIENT;
          end else begin
            state_d     = ST_LAUNCH;
            rsp_dbz_d   = 1'b0;
            div_start_d = 1'b1;
          end
        end
      end

      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (div_done) begin
          rsp_data_d = (op_q == OP_REM) ? div_remainder : div_quotient;
          state_d    = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d = 16'd0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_err_d = 1'b0;
          rsp_dbz_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      div_start_q <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      op_q        <= OP_QUO;
      tag_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_dbz_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      div_start_q <= div_start_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dbz_q   <= rsp_dbz_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign div_start    = div_start_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_tag      = tag_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_dbz      = rsp_dbz_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a 20-cycle behavioural divider and an expectation queue.
module tb_div_issue_ctrl;
  import div_pkg::*;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [15:0]      req_dividend;
  logic [15:0]      req_divisor;
  logic             req_op;
  logic [TAG_W-1:0] req_tag;
  logic             div_start;
  logic [15:0]      div_dividend;
  logic [15:0]      div_divisor;
  logic [15:0]      div_quotient;
  logic [15:0]      div_remainder;
  logic             div_done;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             rsp_dbz;
  logic             busy;

  int errors = 0;
  int checks = 0;
  logic stub_mode = 1'b0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_op(req_op), .req_tag(req_tag),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .rsp_dbz(rsp_dbz), .busy(busy)
  );

  // Behavioural divider: done rises 20 cycles after the start pulse and stays high until the next start.
  function automatic logic [31:0] model_div(input logic [15:0] a, input logic [15:0] b);
    int ai;
    int bi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    return {16'(ai / bi), 16'(ai % bi)};
  endfunction

  int m_cnt;
  always @(posedge clk) begin
    if (reset) begin
      div_done <= 1'b0;
      m_cnt    <= 0;
    end else if (div_start) begin
      div_done <= 1'b0;
      m_cnt    <= stub_mode ? 0 : 19;
      if (div_divisor != 16'd0)
        {div_quotient, div_remainder} <= model_div(div_dividend, div_divisor);
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) div_done <= 1'b1;
    end
  end

  typedef struct {
    logic [15:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
    logic             dbz;
    int               lat;
    int               starts;
  } exp_t;

  exp_t sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic op,
                       input logic [TAG_W-1:0] tag, input logic [15:0] exp_data,
                       input logic exp_err, input logic exp_dbz, input int exp_lat,
                       input int hold);
    exp_t e;
    int   w;
    int   lat;
    int   starts;
    e = '{exp_data, tag, exp_err, exp_dbz, exp_lat, (b == 16'd0) ? 0 : 1};
    sb.push_back(e);

    w = 0;
    while (!req_ready && w < 50) begin
      step();
      w++;
    end
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);

    req_valid    = 1'b1;
    req_dividend = a;
    req_divisor  = b;
    req_op       = op;
    req_tag      = tag;
    step();
    req_valid = 1'b0;

    lat    = 1;
    starts = 0;
    while (!rsp_valid && lat < 100) begin
      if (div_start) begin
        starts++;
        chk("div_operands", {div_dividend, div_divisor}, {a, b});
      end
      step();
      lat++;
    end

    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("rsp_latency", lat, e.lat);
      chk("start_count", starts, e.starts);
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);

      for (int i = 0; i < hold; i++) begin
        step();
        chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("hold_data", {16'd0, rsp_data}, {16'd0, e.data});
        chk("hold_tag", {28'd0, rsp_tag}, {28'd0, e.tag});
        chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      end

      rsp_ready = 1'b1;
      chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
      chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, e.tag});
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      chk("rsp_dbz", {31'd0, rsp_dbz}, {31'd0, e.dbz});
      step();
      rsp_ready = 1'b0;
      chk("post_valid", {31'd0, rsp_valid}, 32'd0);
      chk("post_req_ready", {31'd0, req_ready}, 32'd1);
      chk("post_flags", {30'd0, rsp_err, rsp_dbz}, 32'd0);
    end
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_dividend = '0;
    req_divisor  = '0;
    req_op       = OP_QUO;
    req_tag      = '0;
    rsp_ready    = 1'b0;

    step();
    step();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_div_start", {31'd0, div_start}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    chk("rst_rsp_tag", {28'd0, rsp_tag}, 32'd0);
    chk("rst_flags", {30'd0, rsp_err, rsp_dbz}, 32'd0);
    chk("rst_operands", {div_dividend, div_divisor}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    reset = 1'b0;
    step();

    do_op(16'd100,   16'd7,    OP_QUO, 4'd3, 16'd14,   1'b0, 1'b0, 22, 0);
    do_op(16'd100,   16'd7,    OP_REM, 4'd3, 16'd2,    1'b0, 1'b0, 22, 0);
    do_op(16'hFF9C,  16'd7,    OP_REM, 4'd5, 16'hFFFE, 1'b0, 1'b0, 22, 0);
    do_op(16'hFF9C,  16'd7,    OP_QUO, 4'd6, 16'hFFF2, 1'b0, 1'b0, 22, 0);
    do_op(16'h8000,  16'hFFFF, OP_QUO, 4'd7, 16'h8000, 1'b0, 1'b0, 22, 0);
    do_op(16'd1234,  16'd0,    OP_QUO, 4'd8, 16'hFFFF, 1'b0, 1'b1, 1,  0);
    do_op(16'd1234,  16'd0,    OP_REM, 4'd9, 16'd1234, 1'b0, 1'b1, 1,  0);
    do_op(16'd200,   16'd9,    OP_QUO, 4'd10, 16'd22,  1'b0, 1'b0, 22, 5);

    stub_mode = 1'b1;
    do_op(16'd77,    16'd3,    OP_QUO, 4'd11, 16'd0,   1'b1, 1'b0, 34, 0);
    stub_mode = 1'b0;
    do_op(16'd50,    16'd5,    OP_QUO, 4'd12, 16'd10,  1'b0, 1'b0, 22, 0);

    // Reset lands on the fifth WAIT cycle of an in-flight op.
    req_valid    = 1'b1;
    req_dividend = 16'd1000;
    req_divisor  = 16'd3;
    req_op       = OP_QUO;
    req_tag      = 4'd13;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_start", {31'd0, div_start}, 32'd0);

    do_op(16'd9,     16'd2,    OP_REM, 4'd2, 16'd1,    1'b0, 1'b0, 22, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Execute-stage sequencer that sits directly upstream of the 16-bit signed restoring divider.
- Accepts divide requests from issue logic over a valid/ready handshake, launches the divider with a one-cycle start pulse, and waits for done.
- Short-circuits divide-by-zero, guards against a hung divider with a timeout, and returns the selected quotient or remainder to write-back over a valid/ready handshake.

Parameters:
- TAG_W, 4, width of the destination-register tag carried with each request.
- TIMEOUT_CYCLES, 32, number of WAIT cycles without div_done before the op is aborted (must be >= 20).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_dividend  in  16  signed dividend
- req_divisor  in  16  signed divisor
- req_op  in  1  0 = quotient, 1 = remainder
- req_tag  in  TAG_W  destination tag
- div_start  out  1  one-cycle launch pulse to the divider
- div_dividend  out  16  registered operand to the divider
- div_divisor  out  16  registered operand to the divider
- div_quotient  in  16  divider quotient
- div_remainder  in  16  divider remainder
- div_done  in  1  divider completion
- rsp_valid  out  1  result present
- rsp_ready  in  1  write-back accepts the result
- rsp_data  out  16  selected result
- rsp_tag  out  TAG_W  echoed tag
- rsp_err  out  1  1 = timeout abort
- rsp_dbz  out  1  1 = divide-by-zero
- busy  out  1  state != IDLE

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE, div_start 0, rsp_valid 0, rsp_data 0, rsp_tag 0, rsp_err 0, rsp_dbz 0, operand registers 0, timeout counter 0.
- req_ready = (state == IDLE). Combinational from state only; never depends on req_valid.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - On req_valid & req_ready, latch dividend, divisor, op and tag.
  - If divisor == 0, go to RESP with rsp_dbz = 1. Quotient result is 0xFFFF; remainder result is the dividend. The divider is not started.
  - Otherwise go to LAUNCH.
- LAUNCH: div_start = 1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - div_dividend and div_divisor stay stable from LAUNCH through the end of WAIT.
  - On div_done = 1, capture div_quotient or div_remainder per op into rsp_data and go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES - 1 without done, go to RESP with rsp_err = 1 and rsp_data = 0.
  - div_done is ignored in every state other than WAIT. This avoids a stale done level from the previous op; done drops in the same edge the divider samples start.
- RESP:
  - rsp_valid = 1. rsp_data, rsp_tag, rsp_err and rsp_dbz are held stable while rsp_ready = 0.
  - On rsp_ready = 1, go to IDLE and clear rsp_valid, rsp_err and rsp_dbz.
  - No new request is accepted in the same cycle as the response handshake.
- Latency, with request accepted in cycle t:
  - Normal op: div_start in t+1, div_done first seen in t+21, rsp_valid from t+22.
  - Divide-by-zero: rsp_valid from t+1.
- -32768 / -1 is not special-cased. It passes through the divider, giving quotient 0x8000 and remainder 0.
- Reset mid-operation: next cycle is IDLE, rsp_valid = 0, div_start = 0. The top level drives the divider's reset from the same net, so no in-flight result survives.
- Simultaneous reset and any event: reset wins.

Decomposition:
- Shared package `div_pkg`:
  - state encoding (2-bit: IDLE, LAUNCH, WAIT, RESP);
  - OP_QUO = 0 and OP_REM = 1;
  - DBZ_QUOTIENT = 16'hFFFF;
  - default TIMEOUT_CYCLES.
- No sub-module inside this block. The divider is a sibling, wired to the div_* ports at execute-stage level.
- Timeout counter width is $clog2(TIMEOUT_CYCLES).

Test Plan:
- 100 / 7, op = QUO, tag = 3 -> rsp_data = 14, rsp_tag = 3, err = 0, dbz = 0, rsp_valid exactly 22 cycles after the accept cycle. Repeat with op = REM -> 2.
- -100 / 7: REM -> 0xFFFE (-2); QUO -> 0xFFF2 (-14). Also -32768 / -1, QUO -> 0x8000.
- 1234 / 0: QUO -> 0xFFFF, dbz = 1; REM -> 1234, dbz = 1. rsp_valid one cycle after accept; div_start never asserted.
- Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_tag unchanged, req_ready = 0. Raise rsp_ready -> IDLE next cycle.
- Replace the divider with a stub that never asserts done -> rsp_err = 1 and rsp_data = 0 after 32 WAIT cycles. Then send 50 / 5 QUO with the real divider -> 10.
- Assert reset on the 5th WAIT cycle -> IDLE next cycle, rsp_valid = 0, req_ready = 1. A following 9 / 2 REM request -> 1, correct latency.
